// File: rtl/tuning_word_loader.sv
// Framed byte parser (A5 load / 5A control) driving NCO divf/divr strobes and acc_en; LOADER_CHECKSUM_EN adds a cksum byte to load frames.
// Latency: last load byte accepted in N -> wr_divf N+1, wr_divr N+2, in_ready N+3; control byte -> acc_en two cycles later.
// Backpressure: in_ready low only during the two write cycles; a mid-frame gap of TIMEOUT idle cycles aborts the frame.
module tuning_word_loader #(
  parameter logic [7:0]  SYNC_LOAD = 8'hA5,
  parameter logic [7:0]  SYNC_CTRL = 8'h5A,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] data,
  output logic       wr_divf,
  output logic       wr_divr,
  output logic       acc_en,
  output logic       busy,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE, GET_R, GET_F,
`ifdef LOADER_CHECKSUM_EN
    GET_CK,
`endif
    GET_CTL, WR_F, WR_R
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic [7:0]    divr_q;
  logic [7:0]    divf_q;
  logic          enable_q;
  logic [TW-1:0] to_cnt;
  logic          xfer;
  logic          in_get;
  logic          bad_hdr;
  logic          timeout_hit;
  logic          ck_fail;
  logic          load_done;
  logic          err_evt;

  assign in_ready = (state != WR_F) && (state != WR_R);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid && in_ready;
  assign in_get   = (state != IDLE) && in_ready;
  assign bad_hdr  = (state == IDLE) && xfer && (in_data != SYNC_LOAD) && (in_data != SYNC_CTRL);

  generate
    if (TIMEOUT == 0) begin : g_no_to
      assign timeout_hit = 1'b0;
    end else begin : g_to
      assign timeout_hit = in_get && !xfer && (to_cnt == TW'(TIMEOUT - 1));
    end
  endgenerate

`ifdef LOADER_CHECKSUM_EN
  logic ck_ok;
  assign ck_ok     = (in_data == (SYNC_LOAD ^ divr_q ^ divf_q));
  assign ck_fail   = (state == GET_CK) && xfer && !ck_ok;
  assign load_done = (state == GET_CK) && xfer && ck_ok;
`else
  assign ck_fail   = 1'b0;
  assign load_done = (state == GET_F) && xfer;
`endif

  // All error sources are state-exclusive, so one increment per cycle at most.
  assign err_evt = bad_hdr || timeout_hit || ck_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data     <= 8'h00;
      wr_divf  <= 1'b0;
      wr_divr  <= 1'b0;
      acc_en   <= 1'b0;
      enable_q <= 1'b0;
      err_cnt  <= 8'h00;
      to_cnt   <= '0;
      divr_q   <= 8'h00;
      divf_q   <= 8'h00;
    end else begin
      wr_divf <= 1'b0;
      wr_divr <= 1'b0;
      // Freeze the accumulator for exactly the cycles spent in WR_F and WR_R.
      acc_en  <= enable_q && !(load_done || state == WR_F);

      if (err_evt && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;

      if (xfer || state == IDLE)
        to_cnt <= '0;
      else if (in_get)
        to_cnt <= to_cnt + TW'(1);

      case (state)
        IDLE: begin
          if (xfer && in_data == SYNC_LOAD)      state <= GET_R;
          else if (xfer && in_data == SYNC_CTRL) state <= GET_CTL;
        end
        GET_R: begin
          if (timeout_hit) state <= IDLE;
          else if (xfer) begin
            divr_q <= in_data;
            state  <= GET_F;
          end
        end
        GET_F: begin
          if (timeout_hit) state <= IDLE;
          else if (xfer) begin
            divf_q <= in_data;
`ifdef LOADER_CHECKSUM_EN
            state  <= GET_CK;
`else
            state   <= WR_F;
            wr_divf <= 1'b1;
            data    <= in_data;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        GET_CK: begin
          if (timeout_hit) state <= IDLE;
          else if (xfer) begin
            if (ck_ok) begin
              state   <= WR_F;
              wr_divf <= 1'b1;
              data    <= divf_q;
            end else begin
              state <= IDLE;
            end
          end
        end
`endif
        GET_CTL: begin
          if (timeout_hit) state <= IDLE;
          else if (xfer) begin
            enable_q <= in_data[0];
            state    <= IDLE;
          end
        end
        WR_F: begin
          wr_divr <= 1'b1;
          data    <= divr_q;
          state   <= WR_R;
        end
        WR_R:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tuning_word_loader.sv
// Randomized bench for tuning_word_loader against a frame-level byte-stream model.
`timescale 1ns/1ps
module tb_tuning_word_loader;
  localparam int TO = 32;
`ifdef LOADER_CHECKSUM_EN
  localparam int LLEN = 4;
  localparam bit CK   = 1'b1;
`else
  localparam int LLEN = 3;
  localparam bit CK   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, wr_divf, wr_divr, acc_en, busy;
  logic [7:0] data, err_cnt;

  int tests = 0, fails = 0;
  int cyc = 0, last_xfer = 0;
  logic [7:0]  fb[$];
  logic [15:0] exp_wr[$], obs_wr[$];
  int          exp_err = 0;
  bit          exp_en = 1'b0;
  bit          pend = 1'b0;
  logic [7:0]  pend_f;

  tuning_word_loader #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .data(data), .wr_divf(wr_divf), .wr_divr(wr_divr),
    .acc_en(acc_en), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe monitor: every wr_divf must be followed by exactly one wr_divr.
  always @(negedge clk) begin
    if (!rst_n) pend = 1'b0;
    else begin
      if (pend) begin
        chk("divr_follows", wr_divr, 1'b1);
        chk("divr_acc_en", acc_en, 1'b0);
        chk("divr_in_ready", in_ready, 1'b0);
        obs_wr.push_back({pend_f, data});
        pend = 1'b0;
      end else if (wr_divr) chk("divr_orphan", wr_divr, 1'b0);
      if (wr_divf) begin
        chk("both_strobes", wr_divr, 1'b0);
        chk("divf_acc_en", acc_en, 1'b0);
        chk("divf_in_ready", in_ready, 1'b0);
        pend   = 1'b1;
        pend_f = data;
      end
    end
  end

  task automatic err_inc();
    if (exp_err < 255) exp_err++;
  endtask

  // c = last clock edge index known to carry no transfer
  task automatic model_timeout(input int c);
    if (fb.size() != 0 && c - last_xfer >= TO) begin
      fb.delete();
      err_inc();
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (fb.size() == 0) begin
      if (b == 8'hA5 || b == 8'h5A) fb.push_back(b);
      else err_inc();
    end else begin
      fb.push_back(b);
      if (fb[0] == 8'h5A && fb.size() == 2) begin
        exp_en = fb[1][0];
        fb.delete();
      end else if (fb[0] == 8'hA5 && fb.size() == LLEN) begin
        if (!CK || fb[LLEN-1] == (8'hA5 ^ fb[1] ^ fb[2])) exp_wr.push_back({fb[2], fb[1]});
        else err_inc();
        fb.delete();
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int w;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 10) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", in_ready, 1'b1);
      in_valid = 1'b0;
    end else begin
      tick();
      in_valid = 1'b0;
      model_timeout(cyc - 1);
      model_byte(b);
      last_xfer = cyc;
    end
  endtask

  task automatic send_load(input logic [7:0] r, input logic [7:0] f);
    send(8'hA5, 0);
    send(r, 0);
    send(f, 0);
    if (CK) send(8'hA5 ^ r ^ f, 0);
  endtask

  task automatic check_writes();
    chk("write_count", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      chk("write_data", obs_wr[i], exp_wr[i]);
    exp_wr.delete();
    obs_wr.delete();
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
    model_timeout(cyc);
    chk("err_cnt", err_cnt, exp_err);
    chk("acc_en", acc_en, exp_en);
    chk("busy", busy, fb.size() != 0);
    check_writes();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    chk("rst_wr_divf", wr_divf, 1'b0);
    chk("rst_wr_divr", wr_divr, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_acc_en", acc_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    fb.delete();
    exp_wr.delete();
    obs_wr.delete();
    exp_err   = 0;
    exp_en    = 1'b0;
    last_xfer = cyc;
  endtask

  initial begin
    logic [7:0] r, f, b;
    int kind, g;

    tick();
    do_reset();
    settle(3);

    // control frame enables the accumulator
    send(8'h5A, 0);
    send(8'h01, 0);
    tick();
    chk("ctl_acc_en", acc_en, 1'b1);
    chk("ctl_busy", busy, 1'b0);
    settle(2);

    // exact write timing of a load frame
    send_load(8'h12, 8'h34);
    chk("n1_wr_divf", wr_divf, 1'b1);
    chk("n1_wr_divr", wr_divr, 1'b0);
    chk("n1_data", data, 8'h34);
    chk("n1_acc_en", acc_en, 1'b0);
    chk("n1_in_ready", in_ready, 1'b0);
    tick();
    chk("n2_wr_divr", wr_divr, 1'b1);
    chk("n2_wr_divf", wr_divf, 1'b0);
    chk("n2_data", data, 8'h12);
    chk("n2_acc_en", acc_en, 1'b0);
    chk("n2_in_ready", in_ready, 1'b0);
    tick();
    chk("n3_in_ready", in_ready, 1'b1);
    chk("n3_wr_divr", wr_divr, 1'b0);
    chk("n3_acc_en", acc_en, 1'b1);
    chk("n3_data_hold", data, 8'h12);
    settle(2);

    // bad header counting and saturation
    send(8'h77, 0);
    settle(2);
    for (int i = 0; i < 300; i++) send(8'h77, 0);
    settle(2);
    chk("err_sat", err_cnt, 8'hFF);
    do_reset();
    settle(2);

    // timeout after A5,12, then a clean load
    send(8'hA5, 0);
    send(8'h12, 0);
    repeat (TO) tick();
    settle(0);
    send_load(8'h56, 8'h78);
    settle(4);
    // gap of TO-1 idle cycles must not abort
    send(8'hA5, 0);
    send(8'h56, TO - 1);
    send(8'h78, 0);
    if (CK) send(8'hA5 ^ 8'h56 ^ 8'h78, 0);
    settle(4);

    if (CK) begin
      send(8'hA5, 0);
      send(8'h12, 0);
      send(8'h34, 0);
      send(8'h00, 0);
      settle(4);
    end

    // reset pulse while a load frame is half received
    send(8'hA5, 0);
    send(8'h12, 0);
    do_reset();
    settle(4);

    for (int it = 0; it < 250; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        r = 8'($urandom);
        f = 8'($urandom);
        b = 8'hA5 ^ r ^ f;
        if ($urandom_range(0, 3) == 0) b = b ^ 8'($urandom_range(1, 255));
        send(8'hA5, $urandom_range(0, 2));
        for (int k = 1; k < LLEN; k++) begin
          g = ($urandom_range(0, 19) == 0) ? TO - 1 + $urandom_range(0, 2) : $urandom_range(0, 2);
          send((k == 1) ? r : (k == 2) ? f : b, g);
        end
      end else if (kind < 8) begin
        send(8'h5A, $urandom_range(0, 2));
        g = ($urandom_range(0, 9) == 0) ? TO - 1 + $urandom_range(0, 2) : $urandom_range(0, 2);
        send(8'($urandom), g);
      end else begin
        send(8'($urandom), $urandom_range(0, 2));
      end
      settle(4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
